// File: rtl/gen_rf_pkg.sv
// Shared types and default sizing for the generic register file.
// The sizing constants mirror the core-wide values so the register
// file drops into either the integer or the floating-point pipeline.
package gen_rf_pkg;

   localparam int FLEN         = 64;
   localparam int FREG_NUM     = 32;
   localparam int FREG_IDX_LEN = 5;
   localparam int XLEN         = 64;
   localparam int REG_NUM      = 32;

   typedef enum logic [0:0] {
      RF_CLR_IDLE,
      RF_CLR_BUSY
   } rf_clr_state_t;

endpackage

// File: rtl/gen_rf_clear_ctrl.sv
// Bulk-clear sequencer for the register file.
// Walks the array CLR_STEP registers per cycle.
// It blocks the write ports while a clear is running.
// It emits a registered one-cycle done pulse on completion.
module gen_rf_clear_ctrl
   import gen_rf_pkg::*;
#(
   parameter int  NREG     = 32,
   parameter int  CLR_STEP = 4,
   localparam int IDX_W    = $clog2(NREG)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_req_i,
   output logic             clr_en_o,
   output logic [IDX_W-1:0] clr_base_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ready_o
);

   localparam int K       = NREG / CLR_STEP;
   localparam int CNT_W   = (K > 1) ? $clog2(K) : 1;
   localparam int STEP_SH = $clog2(CLR_STEP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

   rf_clr_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   // Next-state logic: start on request, advance one block per cycle, finish after K blocks
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         RF_CLR_IDLE: begin
            if (clear_req_i) begin
               state_d = RF_CLR_BUSY;
               cnt_d   = '0;
            end
         end
         RF_CLR_BUSY: begin
            if (cnt_q == CNT_LAST) begin
               state_d = RF_CLR_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RF_CLR_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, block counter and done pulse registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RF_CLR_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign clr_en_o   = (state_q == RF_CLR_BUSY);
   assign busy_o     = (state_q == RF_CLR_BUSY);
   assign ready_o    = (state_q == RF_CLR_IDLE);
   assign done_o     = done_q;
   assign clr_base_o = IDX_W'(cnt_q) << STEP_SH;

endmodule

// File: rtl/gen_rf.sv
// Parametrised multi-port register file.
// It provides asynchronous reads and prioritised writes.
// Write-to-read bypass and a hardwired zero register are optional.
// A sequential bulk-clear engine is included.
module gen_rf
   import gen_rf_pkg::*;
#(
   parameter int  DATA_W   = FLEN,
   parameter int  NREG     = FREG_NUM,
   parameter int  NRD      = 3,
   parameter int  NWR      = 2,
   parameter int  ZERO_REG = 0,
   parameter int  BYPASS   = 0,
   parameter int  CLR_STEP = 4,
   localparam int IDX_W    = $clog2(NREG)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NWR-1:0]               comm_valid_i,
   output logic [NWR-1:0]               comm_ready_o,
   input  logic [NWR-1:0][IDX_W-1:0]    comm_rd_idx_i,
   input  logic [NWR-1:0][DATA_W-1:0]   comm_rd_value_i,
   input  logic [NRD-1:0][IDX_W-1:0]    issue_rs_idx_i,
   output logic [NRD-1:0][DATA_W-1:0]   issue_rs_value_o,
   input  logic                         clear_req_i,
   output logic                         clear_busy_o,
   output logic                         clear_done_o
);

   if (NREG % CLR_STEP != 0) begin : g_bad_step_div
      $error("gen_rf: CLR_STEP must divide NREG");
   end
   if (CLR_STEP > NREG) begin : g_bad_step_size
      $error("gen_rf: CLR_STEP must not exceed NREG");
   end
   if (NRD < 1) begin : g_bad_nrd
      $error("gen_rf: NRD must be at least 1");
   end
   if (NWR < 1) begin : g_bad_nwr
      $error("gen_rf: NWR must be at least 1");
   end

   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];
   logic [NWR-1:0]    wr_acc;
   logic              clr_en;
   logic [IDX_W-1:0]  clr_base;
   logic              clr_ready;

   gen_rf_clear_ctrl #(
      .NREG     (NREG),
      .CLR_STEP (CLR_STEP)
   ) u_clear_ctrl (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_req_i (clear_req_i),
      .clr_en_o    (clr_en),
      .clr_base_o  (clr_base),
      .busy_o      (clear_busy_o),
      .done_o      (clear_done_o),
      .ready_o     (clr_ready)
   );

   assign comm_ready_o = {NWR{clr_ready}};
   assign wr_acc       = comm_valid_i & comm_ready_o;

   // Next array contents: later ports overwrite earlier ones, then the clear block, then the zero register
   always_comb begin
      rf_d = rf_q;
      for (int p = 0; p < NWR; p++) begin
         if (wr_acc[p]) begin
            rf_d[comm_rd_idx_i[p]] = comm_rd_value_i[p];
         end
      end
      if (clr_en) begin
         for (int j = 0; j < CLR_STEP; j++) begin
            rf_d[clr_base + IDX_W'(j)] = '0;
         end
      end
      if (ZERO_REG != 0) begin
         rf_d[0] = '0;
      end
   end

   // Storage array
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rf_q <= '{default: '0};
      end else begin
         rf_q <= rf_d;
      end
   end

   // Read ports: array content, optionally overridden by a same-cycle write, with register 0 forced last
   always_comb begin
      for (int r = 0; r < NRD; r++) begin
         issue_rs_value_o[r] = rf_q[issue_rs_idx_i[r]];
         if (BYPASS != 0) begin
            for (int p = 0; p < NWR; p++) begin
               if (wr_acc[p] && (comm_rd_idx_i[p] == issue_rs_idx_i[r])) begin
                  issue_rs_value_o[r] = comm_rd_value_i[p];
               end
            end
         end
         if ((ZERO_REG != 0) && (issue_rs_idx_i[r] == '0)) begin
            issue_rs_value_o[r] = '0;
         end
      end
   end

endmodule
